arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, is the data width per channel in bits; legal range 1..1024.
REQ-002 Parameter NUM_IN, default 4, is the number of input channels; legal range 2..16, need not be a power of two.
REQ-003 Parameter SEL_W, default $clog2(NUM_IN), is the channel-index width; the block SHALL NOT be instantiated with any other value.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_data  input  NUM_IN*WIDTH  flat bus; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  per-channel valid.
REQ-008 in_ready  output  NUM_IN  per-channel ready, at most one bit high per cycle.
REQ-009 out_data  output  WIDTH  registered selected data.
REQ-010 out_valid  output  1  registered output valid.
REQ-011 out_ready  input  1  downstream ready.
REQ-012 out_sel  output  SEL_W  index of the channel whose beat is in out_data.

Function
REQ-013 A channel transfer SHALL occur when in_valid[i] and in_ready[i] are both high at a rising edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-014 load = !out_valid || out_ready; in_ready[i] SHALL equal load && grant[i], driven combinationally.
REQ-015 grant SHALL be one-hot or zero: zero when no in_valid is high, otherwise the single channel chosen by the arbitration policy (REQ-024/025).
REQ-016 On a channel transfer, out_data, out_sel and out_valid=1 SHALL register on the same edge; latency from input transfer to out_valid is exactly 1 cycle.
REQ-017 When load is high and no in_valid is high, out_valid SHALL go to 0 on the next edge, and out_data/out_sel SHALL hold.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL remain stable, and all in_ready bits SHALL be 0.
REQ-019 Sustained throughput SHALL be one beat per cycle when out_ready is held high and any input is valid.
REQ-020 in_ready SHALL NOT depend combinationally on in_data; in_valid-to-in_ready and out_ready-to-in_ready are the only combinational paths.
REQ-021 An in_valid that drops without a transfer SHALL NOT affect arbitration state.

Reset
REQ-022 While rst is high at an edge: out_valid=0, out_data=0, out_sel=0, round-robin pointer=0; in_ready SHALL be all-zero during any cycle in which rst is high.
REQ-023 A beat held in the output register when rst asserts SHALL be discarded; the first grant after reset SHALL follow pointer=0.

Configuration
REQ-024 With ARB_MUX_RR_EN defined: round-robin; grant goes to the first valid channel at or above the pointer, wrapping modulo NUM_IN; on each channel transfer from channel g the pointer SHALL become (g+1) mod NUM_IN, with NUM_IN-1 wrapping to 0.
REQ-025 Without ARB_MUX_RR_EN: fixed priority; grant goes to the lowest-index valid channel; no pointer register is built.

Structure
REQ-026 The shared package arb_mux_pkg SHALL hold the maximum NUM_IN (16) and the index-width helper constant; the design SHALL NOT declare a private copy of either.
REQ-027 Arbitration SHALL be a sub-module rr_arbiter (inputs req, advance; output grant one-hot), with the pointer held internally; arb_mux instantiates it once.

Verification
REQ-028 NUM_IN=4, in_valid=4'b1111, out_ready=1 held for 8 cycles, RR -> out_sel sequence 0,1,2,3,0,1,2,3, one beat per cycle.
REQ-029 Same stimulus without ARB_MUX_RR_EN -> out_sel=0 every cycle; in_ready=4'b0001 throughout.
REQ-030 out_valid=1, out_data=0xA5A5A5A5, out_ready=0 for 5 cycles with in_valid=4'b0110 -> output stable, in_ready=0 each cycle; out_ready=1 -> next beat taken from channel 1.
REQ-031 NUM_IN=3, only channel 2 valid, RR -> pointer wraps to 0; then channels 0 and 2 valid -> channel 0 granted first.
REQ-032 rst pulsed for 1 cycle while out_valid=1 holding channel 3 data -> out_valid=0, out_sel=0, out_data=0 next cycle; that beat never appears at the output.
REQ-033 in_valid=0 with out_ready=1 after a beat -> out_valid falls to 0 one cycle after the output transfer; out_data holds its last value.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// ============================================================================
// Module      : arb_mux_pkg
// Description : Shared constants and helpers for the arb_mux arbiter/mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_mux_pkg;

    localparam int unsigned c_max_num_in = 16;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned c_max_sel_w = idx_width(c_max_num_in);

    // Caller guarantees at most one bit set; a zero vector maps to index 0.
    function automatic logic [c_max_sel_w-1:0] onehot_to_idx(
        input logic [c_max_num_in-1:0] onehot
    );
        logic [c_max_sel_w-1:0] idx;
        idx = '0;
        for (int i = 0; i < c_max_num_in; i++) begin
            if (onehot[i]) begin
                idx = idx | c_max_sel_w'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_mux_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : One-hot arbiter; round-robin when ARB_MUX_RR_EN is defined,
//               fixed lowest-index priority otherwise (no pointer built).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant
);

`ifdef ARB_MUX_RR_EN
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] w_win;
    logic             w_found;

    // Two passes: channels at or above the pointer first, then the wrapped tail.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int c = 0; c < NUM_IN; c++) begin
            if (!w_found && req[c] && (SEL_W'(c) >= ptr_q)) begin
                grant[c] = 1'b1;
                w_found  = 1'b1;
            end
        end
        for (int c = 0; c < NUM_IN; c++) begin
            if (!w_found && req[c] && (SEL_W'(c) < ptr_q)) begin
                grant[c] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign w_win = SEL_W'(onehot_to_idx(c_max_num_in'(grant)));
    assign ptr_d = (w_win == SEL_W'(NUM_IN - 1)) ? '0 : (w_win + SEL_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic w_found;
    logic w_unused;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int c = 0; c < NUM_IN; c++) begin
            if (!w_found && req[c]) begin
                grant[c] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign w_unused = ^{clk, rst, advance};
`endif

endmodule

`default_nettype wire

// File: rtl/arb_mux.sv
// ============================================================================
// Module      : arb_mux
// Description : N-to-1 arbitrated mux with a registered valid/ready output
//               stage. Define ARB_MUX_RR_EN for round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_sel
);

    logic [WIDTH-1:0]  out_data_q;
    logic              out_valid_q;
    logic [SEL_W-1:0]  out_sel_q;

    logic              w_load;
    logic              w_xfer;
    logic [NUM_IN-1:0] w_grant;
    logic [SEL_W-1:0]  w_sel;
    logic [WIDTH-1:0]  w_data;

    assign w_load = !out_valid_q || out_ready;

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    // Grant is already zero when nothing is valid, so any ready bit is a transfer.
    assign in_ready = (w_load && !rst) ? w_grant : '0;
    assign w_xfer   = |in_ready;
    assign w_sel    = SEL_W'(onehot_to_idx(c_max_num_in'(w_grant)));

    always_comb begin
        w_data = '0;
        for (int c = 0; c < NUM_IN; c++) begin
            if (w_grant[c]) begin
                w_data = w_data | in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (w_load) begin
            if (w_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= w_data;
                out_sel_q   <= w_sel;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux.sv
// ============================================================================
// Module      : tb_arb_mux
// Description : Self-checking bench for arb_mux (4-channel and 3-channel
//               instances) against a behavioural arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  vin  [2];
    logic [31:0] din  [2][4];
    logic        ordy [2];

    logic [127:0] a_data;
    logic [95:0]  b_data;
    logic [3:0]   a_rdy;
    logic [2:0]   b_rdy;
    logic [31:0]  a_od, b_od;
    logic         a_ov, b_ov;
    logic [1:0]   a_os, b_os;

    assign a_data = {din[0][3], din[0][2], din[0][1], din[0][0]};
    assign b_data = {din[1][2], din[1][1], din[1][0]};

    arb_mux #(.WIDTH(32), .NUM_IN(4)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(vin[0]),
        .in_ready(a_rdy), .out_data(a_od), .out_valid(a_ov),
        .out_ready(ordy[0]), .out_sel(a_os)
    );

    arb_mux #(.WIDTH(32), .NUM_IN(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(vin[1][2:0]),
        .in_ready(b_rdy), .out_data(b_od), .out_valid(b_ov),
        .out_ready(ordy[1]), .out_sel(b_os)
    );

    logic [3:0]  rdy [2];
    logic [31:0] od  [2];
    logic        ov  [2];
    logic [1:0]  os  [2];
    assign rdy[0] = a_rdy;
    assign rdy[1] = {1'b0, b_rdy};
    assign od[0]  = a_od;
    assign od[1]  = b_od;
    assign ov[0]  = a_ov;
    assign ov[1]  = b_ov;
    assign os[0]  = a_os;
    assign os[1]  = b_os;

    // Reference model state: output register contents and arbitration pointer.
    int          n_ch  [2] = '{4, 3};
    bit          m_ov  [2];
    logic [31:0] m_od  [2];
    int          m_os  [2];
    int          m_ptr [2];

    int checks   = 0;
    int failures = 0;

    function automatic int pick(int k);
`ifdef ARB_MUX_RR_EN
        for (int off = 0; off < n_ch[k]; off++) begin
            int c;
            c = (m_ptr[k] + off) % n_ch[k];
            if (vin[k][c]) return c;
        end
`else
        for (int c = 0; c < n_ch[k]; c++) begin
            if (vin[k][c]) return c;
        end
`endif
        return -1;
    endfunction

    function automatic logic [3:0] exp_rdy(int k);
        int g;
        g = pick(k);
        if (rst || (m_ov[k] && !ordy[k]) || g < 0) return 4'b0000;
        return 4'(1 << g);
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int g;
            g = pick(k);
            if (rst) begin
                m_ov[k]  = 1'b0;
                m_od[k]  = '0;
                m_os[k]  = 0;
                m_ptr[k] = 0;
            end else if (!m_ov[k] || ordy[k]) begin
                if (g >= 0) begin
                    m_ov[k]  = 1'b1;
                    m_od[k]  = din[k][g];
                    m_os[k]  = g;
                    m_ptr[k] = (g + 1) % n_ch[k];
                end else begin
                    m_ov[k] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 4; j++)
                din[k][j] = $urandom;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        vin[0]  = 4'b0000;
        vin[1]  = 4'b0000;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        vin[0]  = 4'b1111;
        vin[1]  = 4'b0111;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        rand_data();
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rdy[k] !== 4'b0000) begin
                failures++;
                $display("FAIL reset_ready k=%0d got=%b exp=0000", k, rdy[k]);
            end
            checks++;
            if (ov[k] !== 1'b0 || od[k] !== 32'h0 || os[k] !== 2'd0) begin
                failures++;
                $display("FAIL reset_out k=%0d got v=%b d=%h s=%0d exp v=0 d=0 s=0",
                         k, ov[k], od[k], os[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        vin[0]  = 4'b1111;
        ordy[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int es;
`ifdef ARB_MUX_RR_EN
            es = i % 4;
`else
            es = 0;
`endif
            rand_data();
            #1;
            checks++;
            if (rdy[0] !== 4'(1 << es)) begin
                failures++;
                $display("FAIL stream_ready i=%0d got=%b exp=%b", i, rdy[0], 4'(1 << es));
            end
            tick();
            checks++;
            if (ov[0] !== 1'b1 || os[0] !== 2'(es) || od[0] !== din[0][es]) begin
                failures++;
                $display("FAIL stream_out i=%0d got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         i, ov[0], os[0], od[0], es, din[0][es]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        vin[0]     = 4'b0001;
        din[0][0]  = 32'hA5A5_A5A5;
        ordy[0]    = 1'b1;
        #1;
        tick();
        ordy[0]   = 1'b0;
        vin[0]    = 4'b0110;
        din[0][1] = $urandom;
        din[0][2] = $urandom;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (rdy[0] !== 4'b0000) begin
                failures++;
                $display("FAIL stall_ready i=%0d got=%b exp=0000", i, rdy[0]);
            end
            tick();
            checks++;
            if (ov[0] !== 1'b1 || od[0] !== 32'hA5A5_A5A5 || os[0] !== 2'd0) begin
                failures++;
                $display("FAIL stall_out i=%0d got v=%b d=%h s=%0d exp v=1 d=a5a5a5a5 s=0",
                         i, ov[0], od[0], os[0]);
            end
        end
        ordy[0] = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 4'b0010) begin
            failures++;
            $display("FAIL release_ready got=%b exp=0010", rdy[0]);
        end
        tick();
        checks++;
        if (ov[0] !== 1'b1 || os[0] !== 2'd1 || od[0] !== din[0][1]) begin
            failures++;
            $display("FAIL release_out got v=%b s=%0d d=%h exp v=1 s=1 d=%h",
                     ov[0], os[0], od[0], din[0][1]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rand_data();
        vin[1]  = 4'b0100;
        ordy[1] = 1'b1;
        #1;
        checks++;
        if (rdy[1] !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_ready2 got=%b exp=0100", rdy[1]);
        end
        tick();
        checks++;
        if (ov[1] !== 1'b1 || os[1] !== 2'd2) begin
            failures++;
            $display("FAIL wrap_out2 got v=%b s=%0d exp v=1 s=2", ov[1], os[1]);
        end
        vin[1] = 4'b0101;
        #1;
        checks++;
        if (rdy[1] !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_ready0 got=%b exp=0001", rdy[1]);
        end
        tick();
        checks++;
        if (os[1] !== 2'd0 || od[1] !== din[1][0]) begin
            failures++;
            $display("FAIL wrap_out0 got s=%0d d=%h exp s=0 d=%h", os[1], od[1], din[1][0]);
        end
        #1;
        checks++;
        if (rdy[1] !== exp_rdy(1)) begin
            failures++;
            $display("FAIL wrap_next got=%b exp=%b", rdy[1], exp_rdy(1));
        end
        tick();
        vin[1] = 4'b0000;
    endtask

    task automatic test_reset_discard();
        do_reset();
        vin[0]    = 4'b1000;
        din[0][3] = $urandom | 32'h1;
        ordy[0]   = 1'b1;
        #1;
        tick();
        ordy[0] = 1'b0;
        vin[0]  = 4'b0000;
        tick();
        checks++;
        if (ov[0] !== 1'b1 || os[0] !== 2'd3 || od[0] !== din[0][3]) begin
            failures++;
            $display("FAIL hold3_out got v=%b s=%0d d=%h exp v=1 s=3 d=%h",
                     ov[0], os[0], od[0], din[0][3]);
        end
        rst    = 1'b1;
        vin[0] = 4'b1111;
        ordy[0] = 1'b1;
        #1;
        checks++;
        if (rdy[0] !== 4'b0000) begin
            failures++;
            $display("FAIL rstpulse_ready got=%b exp=0000", rdy[0]);
        end
        tick();
        rst    = 1'b0;
        vin[0] = 4'b0000;
        checks++;
        if (ov[0] !== 1'b0 || os[0] !== 2'd0 || od[0] !== 32'h0) begin
            failures++;
            $display("FAIL rstpulse_out got v=%b s=%0d d=%h exp v=0 s=0 d=0",
                     ov[0], os[0], od[0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ov[0] !== 1'b0) begin
                failures++;
                $display("FAIL discard_valid i=%0d got=%b exp=0", i, ov[0]);
            end
        end
    endtask

    task automatic test_drain();
        logic [31:0] d;
        do_reset();
        vin[0]    = 4'b0100;
        din[0][2] = $urandom;
        d         = din[0][2];
        ordy[0]   = 1'b1;
        #1;
        tick();
        vin[0] = 4'b0000;
        checks++;
        if (ov[0] !== 1'b1 || od[0] !== d) begin
            failures++;
            $display("FAIL drain_beat got v=%b d=%h exp v=1 d=%h", ov[0], od[0], d);
        end
        tick();
        checks++;
        if (ov[0] !== 1'b0 || od[0] !== d || os[0] !== 2'd2) begin
            failures++;
            $display("FAIL drain_idle got v=%b d=%h s=%0d exp v=0 d=%h s=2",
                     ov[0], od[0], os[0], d);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < 2; k++) begin
                vin[k]  = 4'($urandom) & ((k == 0) ? 4'b1111 : 4'b0111);
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            rand_data();
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rdy[k] !== exp_rdy(k)) begin
                    failures++;
                    $display("FAIL rand_ready i=%0d k=%0d got=%b exp=%b", i, k, rdy[k], exp_rdy(k));
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (ov[k] !== m_ov[k] || od[k] !== m_od[k] || os[k] !== 2'(m_os[k])) begin
                    failures++;
                    $display("FAIL rand_out i=%0d k=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                             i, k, ov[k], od[k], os[k], m_ov[k], m_od[k], m_os[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        vin[0]  = 4'b0000;
        vin[1]  = 4'b0000;
        ordy[0] = 1'b0;
        ordy[1] = 1'b0;
        rand_data();
        #1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_wrap();
        test_reset_discard();
        test_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
